mem_access_unit: RTL and testbench

- Memory stage of the pipeline. Consumes the EX/MEM pipeline-register outputs and runs the data-memory access over a req/gnt/rvalid bus.
- Generates byte enables, store-data lane replication, load lane extraction and sign/zero extension, plus misalignment and bus-timeout detection.
- Drives StallM, which freezes PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Its outputs feed the MEM/WB register.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/lsu_align.sv | 71 +++++++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 access sizes, the load
// ResultSrc code and the bus-access FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load lane
// extraction with sign/zero extension, and misalignment/illegal-funct3 detection.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        fault
);

    logic [31:0]        lane;
    logic signed [7:0]  load_b;
    logic signed [15:0] load_h;
    logic               misalign;
    logic               illegal;

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr[0];
            end
            2'b10: begin
                misalign  = (addr != 2'b00);
            end
            default: begin
                misalign  = 1'b0;
            end
        endcase
    end

    always_comb begin
        if (is_store) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = (funct3 inside {3'b011, 3'b110, 3'b111});
        end
        fault = misalign | illegal;
    end

    // Shift the addressed lane down to bit 0, then extend by size and signedness
    always_comb begin
        lane   = rdata >> {addr, 3'b000};
        load_b = $signed(lane[7:0]);
        load_h = $signed(lane[15:0]);
        case (funct3)
            F3_B:    rdata_ext = {{24{load_b[7]}}, load_b};
            F3_BU:   rdata_ext = {24'h0, lane[7:0]};
            F3_H:    rdata_ext = {{16{load_h[15]}}, load_h};
            F3_HU:   rdata_ext = {16'h0, lane[15:0]};
            F3_W:    rdata_ext = rdata;
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs one data-memory access per instruction over a req/gnt/rvalid
// bus, stalling upstream stages until the access completes or times out.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] InstrM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MemFaultM,
    output logic        BusErrM
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        is_load;
    logic        op;
    logic        fault;
    logic        bus_active;
    logic        timeout;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        unused_instr;

    assign unused_instr = ^{InstrM[31:15], InstrM[11:0]};

    lsu_align u_align (
        .funct3    (InstrM[14:12]),
        .is_store  (MemWriteM),
        .addr      (ALUResultM[1:0]),
        .wdata     (WriteDataM),
        .rdata     (dmem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .fault     (fault)
    );

    assign is_load    = (ResultSrcM == RESULT_SRC_LOAD);
    assign op         = MemWriteM | is_load;
    assign bus_active = op & ~fault;
    assign timeout    = (cnt == CNT_W'(TIMEOUT_CYCLES));

    // Bus fields follow the frozen EX/MEM inputs, so they hold during a stall
    assign dmem_we    = bus_active & MemWriteM;
    assign dmem_addr  = bus_active ? {ALUResultM[31:2], 2'b00} : 32'h0;
    assign dmem_be    = bus_active ? be : 4'b0000;
    assign dmem_wdata = (bus_active & MemWriteM) ? wdata_rep : 32'h0;

    // Gated by n_rst so an abort in reset drops the request in the same cycle
    assign dmem_req  = n_rst & (((state == IDLE) & bus_active) | (state == REQ));
    assign StallM    = n_rst & (((state == IDLE) & bus_active) | (state == REQ) |
                                (state == RESP));
    assign MemFaultM = (state == IDLE) & op & fault;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ReadDataM <= 32'h0;
            BusErrM   <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus_active) begin
                        if (dmem_gnt) begin
                            state <= MemWriteM ? DONE : RESP;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        state <= MemWriteM ? DONE : RESP;
                        cnt   <= '0;
                    end else if (timeout) begin
                        state     <= DONE;
                        cnt       <= '0;
                        BusErrM   <= 1'b1;
                        ReadDataM <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        state     <= DONE;
                        cnt       <= '0;
                        ReadDataM <= rdata_ext;
                    end else if (timeout) begin
                        state     <= DONE;
                        cnt       <= '0;
                        BusErrM   <= 1'b1;
                        ReadDataM <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a byte-level model predicts bus fields and
// load results, and per-transaction timelines predict req/stall/done cycles.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        n_rst;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] InstrM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MemFaultM;
    logic        BusErrM;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .InstrM      (InstrM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .StallM      (StallM),
        .ReadDataM   (ReadDataM),
        .MemFaultM   (MemFaultM),
        .BusErrM     (BusErrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    logic        exp_req, exp_stall, exp_fault, exp_buserr, exp_we;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [3:0]  exp_be;
    bit          chk_bus, chk_wd, chk_rd, in_done;

    int          req_total, stall_total, buserr_total;
    int          op_cyc, first_free;
    logic [31:0] done_rd;

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = 1 << f3[1:0];
        int off = int'(a[1:0]);
        logic [3:0] b = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = 1 << f3[1:0];
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int n = 1 << f3[1:0];
        int off = int'(a[1:0]);
        logic [31:0] v = '0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(off+j) +: 8];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int n;
        if (st && f3 > 3'd2) return 1'b1;
        if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        n = 1 << f3[1:0];
        return (int'(a[1:0]) % n) != 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("req",    32'(dmem_req),  32'(exp_req));
        check("stall",  32'(StallM),    32'(exp_stall));
        check("fault",  32'(MemFaultM), 32'(exp_fault));
        check("buserr", 32'(BusErrM),   32'(exp_buserr));
        if (chk_bus) begin
            check("we",   32'(dmem_we), 32'(exp_we));
            check("addr", dmem_addr,    exp_addr);
            check("be",   32'(dmem_be), 32'(exp_be));
            if (chk_wd) check("wdata", dmem_wdata, exp_wd);
        end
        if (chk_rd) check("rdata", ReadDataM, exp_rd);
        if (dmem_req) req_total++;
        if (StallM) stall_total++;
        if (BusErrM) buserr_total++;
        if (!StallM && first_free < 0) first_free = op_cyc;
        op_cyc++;
        if (in_done) done_rd = ReadDataM;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        MemWriteM = 1'b0; ResultSrcM = 2'b00; InstrM = 32'h0;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_fault = 1'b0; exp_buserr = 1'b0;
        exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wd = 32'h0;
        chk_bus = 1'b1; chk_wd = 1'b1; chk_rd = 1'b0; in_done = 1'b0;
    endtask

    task automatic drive_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd);
        MemWriteM  = st;
        ResultSrcM = st ? 2'b00 : 2'b01;
        InstrM     = {17'h0, f3, 5'h0, 7'b0000011};
        ALUResultM = a;
        WriteDataM = wd;
        dmem_rdata = rd;
        exp_we   = st;
        exp_addr = {a[31:2], 2'b00};
        exp_be   = m_be(f3, a);
        exp_wd   = m_wdata(f3, wd);
        chk_wd   = st;
    endtask

    // g = request cycle carrying gnt (g < 0: never granted); r = cycles after grant to rvalid
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int g, input int r, output int n_req, output int n_stall);
        int req0 = req_total;
        int stall0 = stall_total;
        int req_len = (g < 0) ? TMO + 2 : g + 1;
        drive_op(st, f3, a, wd, rd);
        op_cyc = 0;
        first_free = -1;
        if (m_fault(st, f3, a)) begin
            exp_req = 1'b0; exp_stall = 1'b0; exp_fault = 1'b1; chk_bus = 1'b0;
            cycle();
        end else begin
            exp_fault = 1'b0; chk_bus = 1'b1;
            for (int k = 0; k < req_len; k++) begin
                dmem_gnt = (k == g); dmem_rvalid = 1'b0;
                exp_req = 1'b1; exp_stall = 1'b1; exp_buserr = 1'b0; chk_rd = 1'b0;
                cycle();
            end
            if (g >= 0 && !st) begin
                for (int k = 1; k <= r; k++) begin
                    dmem_gnt = 1'b0; dmem_rvalid = (k == r);
                    exp_req = 1'b0; exp_stall = 1'b1;
                    cycle();
                end
            end
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            exp_req = 1'b0; exp_stall = 1'b0; exp_buserr = (g < 0);
            chk_rd = (!st || g < 0);
            exp_rd = (g < 0) ? 32'h0 : m_load(f3, a, rd);
            in_done = 1'b1;
            cycle();
        end
        n_req = req_total - req0;
        n_stall = stall_total - stall0;
        set_idle();
        cycle();
    endtask

    int nr, ns, bz;

    initial begin
        n_chk = 0; n_err = 0;
        req_total = 0; stall_total = 0; buserr_total = 0;
        op_cyc = 0; first_free = -1; done_rd = 32'h0;
        exp_rd = 32'h0; dmem_rdata = 32'h0;
        n_rst = 1'b0;
        set_idle();

        // reset state
        chk_rd = 1'b1; exp_rd = 32'h0;
        cycle();
        cycle();
        n_rst = 1'b1;
        set_idle();
        cycle();

        // pin the model with hand-computed values
        check("model_lb",  m_load(F3_LB(), 32'h103, 32'h80FF_1234), 32'hFFFF_FF80);
        check("model_lbu", m_load(3'b100, 32'h103, 32'h80FF_1234), 32'h0000_0080);
        check("model_lh",  m_load(3'b001, 32'h102, 32'h80FF_1234), 32'hFFFF_80FF);
        check("model_be_h", 32'(m_be(3'b001, 32'h202)), 32'h0000_000C);
        check("model_wd_h", m_wdata(3'b001, 32'h0000_ABCD), 32'hABCD_ABCD);
        check("model_wd_b", m_wdata(3'b000, 32'h1234_5678), 32'h7878_7878);

        // SW, gnt immediately: one request cycle, DONE on the second cycle
        run_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, nr, ns);
        check("sw_req_cycles", 32'(nr), 32'd1);
        check("sw_stall_cycles", 32'(ns), 32'd1);
        check("sw_done_cycle", 32'(first_free), 32'd1);

        // LB / LBU from the top byte lane
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, nr, ns);
        check("lb_result", done_rd, 32'hFFFF_FF80);
        check("lb_done_cycle", 32'(first_free), 32'd2);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, nr, ns);
        check("lbu_result", done_rd, 32'h0000_0080);

        // SH with grant delayed three cycles
        run_op(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3, 0, nr, ns);
        check("sh_req_cycles", 32'(nr), 32'd4);
        check("sh_stall_cycles", 32'(ns), 32'd4);

        // halfword and word loads with slower handshakes
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 1, 2, nr, ns);
        check("lh_result", done_rd, 32'hFFFF_80FF);
        check("lh_stall_cycles", 32'(ns), 32'd4);
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 0, 1, nr, ns);
        check("lhu_result", done_rd, 32'h0000_80FF);
        run_op(1'b1, 3'b000, 32'h101, 32'h1234_5678, 32'h0, 1, 0, nr, ns);
        run_op(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, 0, 1, nr, ns);
        check("lw_result", done_rd, 32'hCAFE_F00D);

        // faults: no request, no stall
        bz = req_total;
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, nr, ns);
        check("lw_mis_stall", 32'(ns), 32'd0);
        run_op(1'b0, 3'b001, 32'h203, 32'h0, 32'h0, 0, 1, nr, ns);
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, nr, ns);
        run_op(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, nr, ns);
        run_op(1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, nr, ns);
        check("fault_req_cycles", 32'(req_total - bz), 32'd0);

        // timeout: gnt never arrives
        bz = buserr_total;
        run_op(1'b0, 3'b010, 32'h108, 32'h0, 32'h5555_AAAA, -1, 0, nr, ns);
        check("tmo_req_cycles", 32'(nr), 32'd6);
        check("tmo_buserr_pulses", 32'(buserr_total - bz), 32'd1);
        check("tmo_result", done_rd, 32'h0);

        // reset during RESP, stray rvalid afterwards, then a normal load
        drive_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h9999_9999);
        exp_fault = 1'b0; chk_bus = 1'b1; chk_rd = 1'b0; exp_buserr = 1'b0;
        dmem_gnt = 1'b1; exp_req = 1'b1; exp_stall = 1'b1;
        cycle();
        dmem_gnt = 1'b0; exp_req = 1'b0; exp_stall = 1'b1;
        cycle();
        n_rst = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; chk_bus = 1'b0; chk_rd = 1'b1; exp_rd = 32'h0;
        cycle();
        dmem_rvalid = 1'b1;
        cycle();
        set_idle();
        n_rst = 1'b1;
        dmem_rvalid = 1'b1;
        chk_rd = 1'b1; exp_rd = 32'h0;
        cycle();
        dmem_rvalid = 1'b0;
        cycle();
        run_op(1'b0, 3'b010, 32'h10C, 32'h0, 32'h1122_3344, 0, 1, nr, ns);
        check("post_reset_lw", done_rd, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    function automatic logic [2:0] F3_LB();
        return 3'b000;
    endfunction

endmodule
